clk_rst_seq: RTL and testbench
==============================

# clk_rst_seq

Synthesizable, parametrised reset sequencer and clock-enable generator for the SPI environment and DUT-side logic. It takes one free-running clock and an asynchronous active-low reset, and synchronises the reset release. It then holds the design in reset for a programmable number of cycles and releases NUM_CH channel resets in staggered order. Each released channel gets its own programmable clock-enable divider, and a software reset request re-runs the whole sequence without toggling the external reset.

## Interface
Parameters:
- NUM_CH, 4: number of reset/clock-enable channels (1..16).
- RST_CYCLES, 16: default hold length in cycles, used when rst_len is 0.
- STAGGER, 4: cycles between successive channel releases; 0 releases all channels together.
- SYNC_STAGES, 2: reset-release synchroniser depth (>=2).
- DIV_W, 8: width of each channel divider value.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous assert, active-low; deassertion is synchronised internally.
- sw_rst_req  in  1  single-cycle request to restart the reset sequence.
- rst_len  in  16  hold length in cycles; 0 selects RST_CYCLES; sampled on entry to HOLD.
- ch_div  in  NUM_CH*DIV_W  per-channel divider value; channel i occupies bits [i*DIV_W +: DIV_W].
- ch_rst_n  out  NUM_CH  per-channel active-low reset.
- ch_clk_en  out  NUM_CH  per-channel single-cycle clock-enable pulse.
- busy  out  1  high while the sequence is running.
- rst_done  out  1  one-cycle pulse when the sequence completes.

## Operation
- **Synchroniser:** rst low immediately clears the SYNC_STAGES flops (async). The internal rst_sync_n rises SYNC_STAGES edges after rst rises. All other state resets asynchronously on rst low.
- **Reset values:** ch_rst_n=0, ch_clk_en=0, busy=1, rst_done=0. State=HOLD, hold counter=0, stagger counter=0, channel pointer=0, dividers=0.
- **FSM states:**
  - HOLD: counts L cycles, where L = rst_len if nonzero, else RST_CYCLES. Then goes to RELEASE.
  - RELEASE: sets ch_rst_n[ptr]=1, increments ptr, then waits STAGGER cycles before the next channel. After channel NUM_CH-1 it goes to RUN.
  - RUN: busy=0. Stays here until sw_rst_req.
- **sw_rst_req:**
  - In any state: on the next edge all ch_rst_n=0, ch_clk_en=0, busy=1, state=HOLD, counters cleared, rst_len re-sampled.
  - A request during HOLD or RELEASE restarts the count from zero.
  - sw_rst_req is ignored while rst_sync_n is low.
- **Divider, channel i:**
  - The counter is held at 0 while ch_rst_n[i]=0.
  - Once released, it increments each cycle. ch_clk_en[i]=1 when counter == div_i, and the counter wraps to 0 on that cycle.
  - div_i is the ch_div slice, latched on release and at each wrap. Changes mid-period take effect after the next pulse.
  - div_i=0 gives ch_clk_en[i] constantly high while released.
- **Width rule:** L=65535 must work; the hold counter is 16 bits and the stagger counter is clog2(STAGGER+1) bits.

## Timing
- E0 is the first edge at which rst_sync_n is high.
- ch_rst_n[0] rises at edge E0+L.
- ch_rst_n[i] rises at edge E0+L+i*STAGGER.
- When STAGGER=0, all channels rise at E0+L.
- busy falls and rst_done pulses high on the same edge that ch_rst_n[NUM_CH-1] rises. rst_done lasts exactly one cycle.
- The first ch_clk_en[i] pulse occurs div_i+1 edges after ch_rst_n[i] rises; the period is div_i+1 cycles.
- A sw_rst_req sampled at edge S gives ch_rst_n=0 at S. With a new L', channel 0 rises at S+1+L'.
- rst low mid-sequence: all outputs go to reset values asynchronously, with no glitch on ch_rst_n.
- rst_done and sw_rst_req on the same edge: the request wins. rst_done still pulses for that cycle, and busy returns high on the next edge.

## Test plan
- **Power-on, defaults (NUM_CH=4, RST_CYCLES=16, STAGGER=4, SYNC_STAGES=2), rst released at edge 0, rst_len=0:**
  - ch_rst_n[0..3] rise at edges 18, 22, 26, 30.
  - rst_done pulses at edge 30 only; busy is low from edge 30.
- **Divider, ch_div={3,0,1,7}:**
  - ch0 pulses every 4 cycles, first pulse 4 edges after its release.
  - ch1 is steady high.
  - ch2 pulses every 2 cycles.
  - ch3 pulses every 8 cycles.
  - Changing ch0 to 5 mid-period changes its period only after the next pulse.
- **sw_rst_req in RUN with rst_len=5:**
  - All ch_rst_n are low on the sampling edge and all ch_clk_en stop.
  - ch_rst_n[0] rises 6 edges later; busy is high throughout; rst_done pulses again.
- **sw_rst_req during RELEASE after 2 channels are released:**
  - Released channels drop to 0 and HOLD restarts.
  - The release order 0..3 is repeated with full STAGGER spacing.
- **Async rst pulse of 3 ns, mid-HOLD and mid-RUN:**
  - Outputs go to reset values immediately.
  - The sequence restarts from synchroniser depth.
  - No ch_rst_n rises before E0+L.
- **STAGGER=0, NUM_CH=1, rst_len=65535:**
  - Single release at E0+65535; rst_done coincides with it.
  - No counter overflow.

Source files
------------

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - reset sequencer with staggered channel release and per-channel clock-enable dividers
module clk_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int RST_CYCLES  = 16,
  parameter int STAGGER     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_rst_req,
  input  logic [15:0]             rst_len,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH-1:0]       ch_clk_en,
  output logic                    busy,
  output logic                    rst_done
);

  localparam int STG_W = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [STG_W-1:0] STG_RELOAD = STG_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [15:0]       hold_q, hold_d;
  logic [15:0]       len_q, len_d;
  logic [STG_W-1:0]  stg_q, stg_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       hold_len;

  assign hold_len = (len_q != 16'd0) ? len_q : 16'(RST_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HOLD;
      hold_q     <= '0;
      len_q      <= '0;
      stg_q      <= '0;
      ptr_q      <= '0;
      ch_rst_n_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      len_q      <= len_d;
      stg_q      <= stg_d;
      ptr_q      <= ptr_d;
      ch_rst_n_q <= ch_rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    len_d      = len_q;
    stg_d      = stg_q;
    ptr_d      = ptr_q;
    ch_rst_n_d = ch_rst_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (!rst_sync_n || sw_rst_req) begin
      // Both the unsynchronised window and a software request park everything at HOLD start.
      state_d    = HOLD;
      hold_d     = '0;
      len_d      = rst_len;
      stg_d      = '0;
      ptr_d      = '0;
      ch_rst_n_d = '0;
      busy_d     = 1'b1;
      // A completion on the request edge still reports itself.
      done_d     = rst_sync_n && (state_q == RELEASE) && (stg_q == '0) &&
                   ((STAGGER == 0) || (ptr_q == PTR_LAST));
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_q == hold_len - 16'd1) begin
            state_d = RELEASE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        RELEASE: begin
          if (STAGGER == 0) begin
            ch_rst_n_d = '1;
            state_d    = RUN;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else if (stg_q != '0) begin
            stg_d = stg_q - STG_W'(1);
          end else begin
            ch_rst_n_d[ptr_q] = 1'b1;
            if (ptr_q == PTR_LAST) begin
              state_d = RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              ptr_d = ptr_q + PTR_W'(1);
              stg_d = STG_RELOAD;
            end
          end
        end
        RUN:     ;
        default: state_d = HOLD;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_div
    logic [DIV_W-1:0] cnt_q, div_q;
    logic             en_q;

    // Held (and reloading div) until the edge after release, so the first pulse lands div+1 edges later.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        div_q <= '0;
        en_q  <= 1'b0;
      end else if (!ch_rst_n_q[i] || !ch_rst_n_d[i]) begin
        cnt_q <= '0;
        div_q <= ch_div[i*DIV_W +: DIV_W];
        en_q  <= 1'b0;
      end else if (cnt_q == div_q) begin
        cnt_q <= '0;
        div_q <= ch_div[i*DIV_W +: DIV_W];
        en_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
        en_q  <= 1'b0;
      end
    end

    assign ch_clk_en[i] = en_q;
  end

  assign ch_rst_n = ch_rst_n_q;
  assign busy     = busy_q;
  assign rst_done = done_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - self-checking bench for clk_rst_seq with a release-time model
module tb_clk_rst_seq;

  localparam int NUM_CH      = 4;
  localparam int RST_CYCLES  = 16;
  localparam int STAGGER     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DIV_W       = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    sw_rst_req = 1'b0;
  logic [15:0]             rst_len = 16'd0;
  logic [NUM_CH*DIV_W-1:0] ch_div = '0;
  logic [NUM_CH-1:0]       ch_rst_n, ch_clk_en;
  logic                    busy, rst_done;

  logic        rst_b = 1'b1;
  logic [7:0]  ch_div_b = 8'd2;
  logic [0:0]  ch_rst_n_b, ch_clk_en_b;
  logic        busy_b, rst_done_b;

  always #5 clk = ~clk;

  clk_rst_seq #(.NUM_CH(NUM_CH), .RST_CYCLES(RST_CYCLES), .STAGGER(STAGGER),
                .SYNC_STAGES(SYNC_STAGES), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .rst_len(rst_len), .ch_div(ch_div),
    .ch_rst_n(ch_rst_n), .ch_clk_en(ch_clk_en), .busy(busy), .rst_done(rst_done));

  clk_rst_seq #(.NUM_CH(1), .RST_CYCLES(16), .STAGGER(0), .SYNC_STAGES(2), .DIV_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .sw_rst_req(1'b0), .rst_len(16'hFFFF), .ch_div(ch_div_b),
    .ch_rst_n(ch_rst_n_b), .ch_clk_en(ch_clk_en_b), .busy(busy_b), .rst_done(rst_done_b));

  int n_checks = 0;
  int n_fails  = 0;

  longint cyc = 0;
  longint rel0 = 0;
  bit     have_rel0 = 1'b0;
  int     rel_n = -1;
  int     rst_run = 0;
  bit     started = 1'b0;
  longint start_e = 0;
  longint seq_len = 0;
  longint nxt [NUM_CH];
  logic [NUM_CH-1:0] e_rst_n = '0, e_en = '0;
  logic              e_busy = 1'b1, e_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @edge %0d: got %0h, want %0h", name, rel_n, act, exp);
    end
  endtask

  function automatic longint len_of(input logic [15:0] v);
    return (v == 16'd0) ? longint'(RST_CYCLES) : longint'(v);
  endfunction

  always @(negedge rst) begin
    rst_run = 0;
    started = 1'b0;
    e_rst_n = '0;
    e_en    = '0;
    e_busy  = 1'b1;
    e_done  = 1'b0;
  end

  // Model: a sequence is a start edge plus a length; every output follows from release times.
  always @(posedge clk) begin
    longint rel_i, last;
    cyc++;
    if (!rst) begin
      rst_run = 0;
      started = 1'b0;
    end else begin
      if (rst_run < 1000) rst_run++;
      if (!have_rel0) begin
        rel0 = cyc;
        have_rel0 = 1'b1;
      end
    end
    rel_n = have_rel0 ? int'(cyc - rel0) : -1;
    if (rst_run == SYNC_STAGES + 1) begin
      started = 1'b1;
      start_e = cyc;
      seq_len = len_of(rst_len);
    end
    if (rst_run >= SYNC_STAGES + 1 && sw_rst_req) begin
      start_e = cyc + 1;
      seq_len = len_of(rst_len);
    end
    if (!started) begin
      e_rst_n = '0;
      e_en    = '0;
      e_busy  = 1'b1;
      e_done  = 1'b0;
    end else begin
      last = start_e + seq_len + longint'((NUM_CH - 1) * STAGGER);
      for (int i = 0; i < NUM_CH; i++) begin
        rel_i = start_e + seq_len + longint'(i * STAGGER);
        e_rst_n[i] = (cyc >= rel_i);
        e_en[i]    = (cyc > rel_i) && (cyc == nxt[i]);
        if (cyc == rel_i || cyc == nxt[i])
          nxt[i] = cyc + longint'(ch_div[i*DIV_W +: DIV_W]) + 1;
      end
      e_busy = (cyc < last);
      e_done = (cyc == last);
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("ch_rst_n", 32'(ch_rst_n), 32'(e_rst_n));
      chk("ch_clk_en", 32'(ch_clk_en), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("rst_done", 32'(rst_done), 32'(e_done));
    end
  end

  task automatic at_edge(input int k);
    int guard = 0;
    while (rel_n < k && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (rel_n != k) begin
      n_checks++;
      n_fails++;
      $display("FAIL at_edge: reached %0d, want %0d", rel_n, k);
    end
  endtask

  task automatic async_pulse();
    #1 rst = 1'b0;
    #2;
    chk("async_rst_n", 32'(ch_rst_n), 32'h0);
    chk("async_en", 32'(ch_clk_en), 32'h0);
    chk("async_busy", 32'(busy), 32'h1);
    chk("async_done", 32'(rst_done), 32'h0);
    #1 rst = 1'b1;
  endtask

  initial begin
    ch_div = {8'd7, 8'd1, 8'd0, 8'd3};
    #1 rst = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rst_n", 32'(ch_rst_n), 32'h0);
    chk("reset_en", 32'(ch_clk_en), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_done", 32'(rst_done), 32'h0);
    chk("reset_b_busy", 32'(busy_b), 32'h1);
    rst = 1'b1;
    rst_b = 1'b1;

    at_edge(17); chk("e17_rst_n", 32'(ch_rst_n), 32'h0);
    at_edge(18); chk("e18_rst_n", 32'(ch_rst_n), 32'h1);
    chk("model_e0", 32'(start_e - rel0), 32'd2);
    chk("model_e18", 32'(e_rst_n), 32'h1);
    at_edge(22); chk("e22_rst_n", 32'(ch_rst_n), 32'h3); chk("e22_en", 32'(ch_clk_en), 32'h1);
    at_edge(23); chk("e23_en", 32'(ch_clk_en), 32'h2);
    at_edge(26); chk("e26_rst_n", 32'(ch_rst_n), 32'h7); chk("e26_en", 32'(ch_clk_en), 32'h3);
    at_edge(28); chk("e28_en", 32'(ch_clk_en), 32'h6);
    at_edge(29); chk("e29_done", 32'(rst_done), 32'h0); chk("e29_busy", 32'(busy), 32'h1);
    at_edge(30); chk("e30_rst_n", 32'(ch_rst_n), 32'hF); chk("e30_done", 32'(rst_done), 32'h1);
    chk("e30_busy", 32'(busy), 32'h0); chk("model_e30_done", 32'(e_done), 32'h1);
    at_edge(31); chk("e31_done", 32'(rst_done), 32'h0); chk("e31_busy", 32'(busy), 32'h0);
    at_edge(38); chk("e38_en", 32'(ch_clk_en), 32'hF);
    at_edge(40); ch_div[7:0] = 8'd5;
    at_edge(42); chk("e42_en0", 32'(ch_clk_en[0]), 32'h1);
    at_edge(46); chk("e46_en0", 32'(ch_clk_en[0]), 32'h0);
    at_edge(48); chk("e48_en0", 32'(ch_clk_en[0]), 32'h1);
    at_edge(54); chk("e54_en0", 32'(ch_clk_en[0]), 32'h1);

    at_edge(60); rst_len = 16'd5; sw_rst_req = 1'b1;
    at_edge(61); sw_rst_req = 1'b0;
    chk("sw_run_rst_n", 32'(ch_rst_n), 32'h0); chk("sw_run_en", 32'(ch_clk_en), 32'h0);
    chk("sw_run_busy", 32'(busy), 32'h1);
    at_edge(66); chk("e66_rst_n", 32'(ch_rst_n), 32'h0); chk("e66_busy", 32'(busy), 32'h1);
    at_edge(67); chk("e67_rst_n", 32'(ch_rst_n), 32'h1);
    at_edge(79); chk("e79_rst_n", 32'(ch_rst_n), 32'hF); chk("e79_done", 32'(rst_done), 32'h1);

    at_edge(99); sw_rst_req = 1'b1;
    at_edge(100); sw_rst_req = 1'b0;
    at_edge(111); chk("e111_rst_n", 32'(ch_rst_n), 32'h3); sw_rst_req = 1'b1;
    at_edge(112); sw_rst_req = 1'b0;
    chk("sw_rel_rst_n", 32'(ch_rst_n), 32'h0); chk("sw_rel_busy", 32'(busy), 32'h1);
    at_edge(117); chk("e117_rst_n", 32'(ch_rst_n), 32'h0);
    at_edge(118); chk("e118_rst_n", 32'(ch_rst_n), 32'h1);
    at_edge(122); chk("e122_rst_n", 32'(ch_rst_n), 32'h3);
    at_edge(126); chk("e126_rst_n", 32'(ch_rst_n), 32'h7);
    at_edge(130); chk("e130_rst_n", 32'(ch_rst_n), 32'hF); chk("e130_done", 32'(rst_done), 32'h1);

    at_edge(139); sw_rst_req = 1'b1;
    at_edge(140); sw_rst_req = 1'b0;
    at_edge(143); async_pulse();
    at_edge(150); chk("e150_rst_n", 32'(ch_rst_n), 32'h0);
    at_edge(151); chk("e151_rst_n", 32'(ch_rst_n), 32'h1);
    at_edge(163); chk("e163_done", 32'(rst_done), 32'h1);

    at_edge(180); async_pulse();
    at_edge(187); chk("e187_rst_n", 32'(ch_rst_n), 32'h0);
    at_edge(188); chk("e188_rst_n", 32'(ch_rst_n), 32'h1);
    at_edge(200); chk("e200_rst_n", 32'(ch_rst_n), 32'hF); chk("e200_done", 32'(rst_done), 32'h1);

    at_edge(65536); chk("b_pre_rst_n", 32'(ch_rst_n_b), 32'h0); chk("b_pre_busy", 32'(busy_b), 32'h1);
    at_edge(65537); chk("b_rel_rst_n", 32'(ch_rst_n_b), 32'h1); chk("b_rel_done", 32'(rst_done_b), 32'h1);
    chk("b_rel_busy", 32'(busy_b), 32'h0);
    at_edge(65538); chk("b_post_done", 32'(rst_done_b), 32'h0); chk("b_post_rst_n", 32'(ch_rst_n_b), 32'h1);
    at_edge(65539); chk("b_en_early", 32'(ch_clk_en_b), 32'h0);
    at_edge(65540); chk("b_en_first", 32'(ch_clk_en_b), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
